// File: rtl/stream_timed_out.sv
// Final playback stage: holds one {time,data} sample and strobes its data word out
// on the cycle the local board-time counter reaches the sample's time.
module stream_timed_out #(
  parameter int TIME_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               run_en,
  input  logic [TIME_BITS+DATA_BITS-1:0]     in_data,
  input  logic                               in_last,
  input  logic [(TIME_BITS+DATA_BITS)/8-1:0] in_keep,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_BITS-1:0]               out_data,
  output logic                               out_strobe,
  output logic [TIME_BITS-1:0]               board_time,
  output logic                               status_run,
  output logic                               status_end,
  output logic                               error_time,
  output logic                               error_keep
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_END   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [TIME_BITS-1:0]   r_board_time;
  logic [TIME_BITS-1:0]   r_hold_time;
  logic [DATA_BITS-1:0]   r_hold_data;
  logic                   r_hold_last;
  logic                   r_hold_valid;
  logic [DATA_BITS-1:0]   r_out_data;
  logic                   r_out_strobe;
  logic                   r_error_time;
  logic                   r_error_keep;

  logic w_in_run;
  logic w_accepting;
  logic w_fire;
  logic w_late;
  logic w_overflow;
  logic w_ready;
  logic w_accept;
  logic w_keep_bad;
  logic w_load;
  logic w_to_error;
  logic w_tick;

  // Compare against the current board_time; the increment lands at the same edge.
  assign w_in_run    = (r_state == ST_RUN);
  assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_fire      = w_in_run & run_en & r_hold_valid & (r_hold_time == r_board_time);
  assign w_late      = w_in_run & run_en & r_hold_valid & (r_hold_time < r_board_time);
  assign w_overflow  = w_in_run & run_en & (r_board_time == {TIME_BITS{1'b1}});
  assign w_ready     = w_accepting & (~r_hold_valid | w_fire);
  assign w_accept    = in_valid & w_ready;
  assign w_keep_bad  = w_accept & (in_keep != {((TIME_BITS+DATA_BITS)/8){1'b1}});
  assign w_load      = w_accept & ~w_keep_bad;
  assign w_to_error  = w_late | w_overflow | w_keep_bad;
  // The counter freezes on the edge that enters ERROR, so it never wraps.
  assign w_tick      = w_in_run & run_en & ~w_to_error;

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves the target unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_keep_bad)  w_next_state = ST_ERROR;
        else if (run_en) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_to_error)                 w_next_state = ST_ERROR;
        else if (w_fire && r_hold_last) w_next_state = ST_END;
      end
      ST_END:   w_next_state = ST_END;
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_ERROR;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready   = w_ready;
    status_run = (r_state == ST_RUN);
    status_end = (r_state == ST_END);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_board_time <= '0;
      r_hold_time  <= '0;
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_out_data   <= '0;
      r_out_strobe <= 1'b0;
      r_error_time <= 1'b0;
      r_error_keep <= 1'b0;
    end else begin
      if (w_tick) r_board_time <= r_board_time + 1'b1;

      // A load in the same cycle as a fire replaces the sample being fired.
      if (w_load) begin
        r_hold_time  <= in_data[TIME_BITS+DATA_BITS-1:DATA_BITS];
        r_hold_data  <= in_data[DATA_BITS-1:0];
        r_hold_last  <= in_last;
        r_hold_valid <= 1'b1;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end

      r_out_strobe <= w_fire;
      if (w_fire) r_out_data <= r_hold_data;

      r_error_time <= r_error_time | w_late | w_overflow;
      r_error_keep <= r_error_keep | w_keep_bad;
    end
  end

  assign out_data   = r_out_data;
  assign out_strobe = r_out_strobe;
  assign board_time = r_board_time;
  assign error_time = r_error_time;
  assign error_keep = r_error_keep;

endmodule

// File: tb/tb_stream_timed_out.sv
// Directed scenario bench for stream_timed_out: a 32-bit-time instance for the
// playback scenarios and an 8-bit-time instance to reach counter overflow.
module tb_stream_timed_out;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 32-bit time instance
  logic        reset_n, run_en, in_last, in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_ready, out_strobe, status_run, status_end, error_time, error_keep;
  logic [31:0] out_data, board_time;

  // 8-bit time instance
  logic        b_reset_n, b_run_en, b_in_last, b_in_valid;
  logic [39:0] b_in_data;
  logic [4:0]  b_in_keep;
  logic        b_in_ready, b_out_strobe, b_status_run, b_status_end, b_error_time, b_error_keep;
  logic [31:0] b_out_data;
  logic [7:0]  b_board_time;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_bt[$];
  logic [31:0] q_d[$];

  stream_timed_out dut (
    .clock(clock), .reset_n(reset_n), .run_en(run_en),
    .in_data(in_data), .in_last(in_last), .in_keep(in_keep), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_strobe(out_strobe),
    .board_time(board_time), .status_run(status_run), .status_end(status_end),
    .error_time(error_time), .error_keep(error_keep)
  );

  stream_timed_out #(.TIME_BITS(8), .DATA_BITS(32)) dut_b (
    .clock(clock), .reset_n(b_reset_n), .run_en(b_run_en),
    .in_data(b_in_data), .in_last(b_in_last), .in_keep(b_in_keep), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_strobe(b_out_strobe),
    .board_time(b_board_time), .status_run(b_status_run), .status_end(b_status_end),
    .error_time(b_error_time), .error_keep(b_error_keep)
  );

  // Strobe log: board_time and data seen in each strobe cycle.
  always @(negedge clock) begin
    if (out_strobe) begin
      q_bt.push_back(board_time);
      q_d.push_back(out_data);
    end
  end

  // Present one beat and hold it until the handshake completes (bounded).
  task automatic push(input logic [31:0] t, input logic [31:0] d, input logic last,
                      input logic [7:0] keep, input string name);
    bit ok;
    ok = 1'b0;
    in_data  = {t, d};
    in_last  = last;
    in_keep  = keep;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_accept: no handshake within 200 cycles", name); end
  endtask

  task automatic reset_dut();
    reset_n  = 1'b0;
    run_en   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 8'hFF;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    q_bt.delete();
    q_d.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run_en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_keep = 8'hFF; in_data = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({out_strobe, status_run, status_end, error_time, error_keep} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {out_strobe, status_run, status_end, error_time, error_keep});
    end
    checks++;
    if (board_time !== 32'd0 || out_data !== 32'd0) begin
      errors++; $display("FAIL reset_regs: board_time=%0h out_data=%0h want 0 0", board_time, out_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_sample();
    reset_dut();
    push(32'd0, 32'hA5, 1'b0, 8'hFF, "first");
    run_en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (status_run !== 1'b1 || board_time !== 32'd0 || out_strobe !== 1'b0) begin
      errors++; $display("FAIL first_enter_run: run=%b bt=%0d strobe=%b want 1 0 0",
                         status_run, board_time, out_strobe);
    end
    @(posedge clock); #1;
    checks++;
    if (out_strobe !== 1'b1 || out_data !== 32'hA5 || board_time !== 32'd1) begin
      errors++; $display("FAIL first_strobe: strobe=%b data=%0h bt=%0d want 1 a5 1",
                         out_strobe, out_data, board_time);
    end
    @(posedge clock); #1;
    checks++;
    if (out_strobe !== 1'b0 || out_data !== 32'hA5) begin
      errors++; $display("FAIL first_hold: strobe=%b data=%0h want 0 a5", out_strobe, out_data);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    push(32'd3, 32'd1, 1'b0, 8'hFF, "b2b_t3");
    run_en = 1'b1;
    push(32'd4, 32'd2, 1'b0, 8'hFF, "b2b_t4");
    push(32'd5, 32'd3, 1'b1, 8'hFF, "b2b_t5");
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (q_bt.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d strobes want 3", q_bt.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_bt[i] !== 32'(4 + i) || q_d[i] !== 32'(1 + i)) begin
          errors++; $display("FAIL b2b_strobe%0d: bt=%0d data=%0h want %0d %0h",
                             i, q_bt[i], q_d[i], 4 + i, 1 + i);
        end
      end
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if (status_end !== 1'b1 || status_run !== 1'b0 || board_time !== 32'd6 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_end: end=%b run=%b bt=%0d ready=%b want 1 0 6 0",
                         status_end, status_run, board_time, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pause();
    bit hit;
    hit = 1'b0;
    reset_dut();
    push(32'd10, 32'h77, 1'b0, 8'hFF, "pause_t10");
    run_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (board_time == 32'd8) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL pause_reach8: bt=%0d want 8 within 50 cycles", board_time); end
    run_en = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (board_time !== 32'd8 || q_bt.size() != 0 || status_run !== 1'b1) begin
      errors++; $display("FAIL pause_hold: bt=%0d strobes=%0d run=%b want 8 0 1",
                         board_time, q_bt.size(), status_run);
    end
    run_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_strobe !== 1'b1 || board_time !== 32'd11 || out_data !== 32'h77) begin
      errors++; $display("FAIL pause_resume: strobe=%b bt=%0d data=%0h want 1 11 77",
                         out_strobe, board_time, out_data);
    end
  endtask

  task automatic test_equal_times();
    reset_dut();
    push(32'd5, 32'h11, 1'b0, 8'hFF, "eq_first");
    run_en = 1'b1;
    push(32'd5, 32'h22, 1'b0, 8'hFF, "eq_second");
    checks++;
    if (out_strobe !== 1'b1 || out_data !== 32'h11 || error_time !== 1'b0) begin
      errors++; $display("FAIL eq_first_fire: strobe=%b data=%0h err=%b want 1 11 0",
                         out_strobe, out_data, error_time);
    end
    @(posedge clock); #1;
    checks++;
    if (error_time !== 1'b1 || status_run !== 1'b0 || out_strobe !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL eq_late: err=%b run=%b strobe=%b ready=%b want 1 0 0 0",
                         error_time, status_run, out_strobe, in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (q_bt.size() != 1 || out_data !== 32'h11 || error_keep !== 1'b0) begin
      errors++; $display("FAIL eq_no_second: strobes=%0d data=%0h ekeep=%b want 1 11 0",
                         q_bt.size(), out_data, error_keep);
    end
  endtask

  task automatic test_keep_error();
    reset_dut();
    run_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (board_time !== 32'd3 || status_run !== 1'b1 || error_time !== 1'b0) begin
      errors++; $display("FAIL keep_underflow: bt=%0d run=%b err=%b want 3 1 0",
                         board_time, status_run, error_time);
    end
    push(32'd20, 32'h99, 1'b0, 8'h0F, "keep_bad");
    checks++;
    if (error_keep !== 1'b1 || error_time !== 1'b0 || status_run !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL keep_flag: ekeep=%b etime=%b run=%b ready=%b want 1 0 0 0",
                         error_keep, error_time, status_run, in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (board_time !== 32'd3 || q_bt.size() != 0) begin
      errors++; $display("FAIL keep_frozen: bt=%0d strobes=%0d want 3 0", board_time, q_bt.size());
    end
    run_en  = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({error_keep, error_time, status_run, status_end, out_strobe} !== 5'b0 || board_time !== 32'd0) begin
      errors++; $display("FAIL keep_reset: flags=%b bt=%0d want 00000 0",
                         {error_keep, error_time, status_run, status_end, out_strobe}, board_time);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_midrun();
    reset_dut();
    push(32'd6, 32'h55, 1'b0, 8'hFF, "mid_t6");
    run_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    q_bt.delete();
    q_d.delete();
    repeat (12) @(posedge clock);
    #1;
    checks++;
    if (q_bt.size() != 0 || board_time !== 32'd11 || status_run !== 1'b1 || error_time !== 1'b0) begin
      errors++; $display("FAIL mid_discard: strobes=%0d bt=%0d run=%b err=%b want 0 11 1 0",
                         q_bt.size(), board_time, status_run, error_time);
    end
  endtask

  task automatic test_overflow();
    bit hit;
    hit = 1'b0;
    b_reset_n  = 1'b1;
    b_in_data  = {8'hFE, 32'h5A};
    b_in_keep  = 5'h1F;
    b_in_last  = 1'b0;
    b_in_valid = 1'b1;
    @(negedge clock);
    checks++;
    if (b_in_ready !== 1'b1) begin errors++; $display("FAIL ovf_prefetch: ready=%b want 1", b_in_ready); end
    @(posedge clock); #1;
    b_in_valid = 1'b0;
    b_run_en   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (b_out_strobe) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || b_board_time !== 8'hFF || b_out_data !== 32'h5A || b_error_time !== 1'b0) begin
      errors++; $display("FAIL ovf_strobe: seen=%b bt=%0h data=%0h err=%b want 1 ff 5a 0",
                         hit, b_board_time, b_out_data, b_error_time);
    end
    @(posedge clock); #1;
    checks++;
    if (b_error_time !== 1'b1 || b_status_run !== 1'b0 || b_board_time !== 8'hFF || b_in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_error: err=%b run=%b bt=%0h ready=%b want 1 0 ff 0",
                         b_error_time, b_status_run, b_board_time, b_in_ready);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (b_board_time !== 8'hFF || b_out_strobe !== 1'b0 || b_error_keep !== 1'b0 || b_status_end !== 1'b0) begin
      errors++; $display("FAIL ovf_nowrap: bt=%0h strobe=%b ekeep=%b end=%b want ff 0 0 0",
                         b_board_time, b_out_strobe, b_error_keep, b_status_end);
    end
  endtask

  initial begin
    b_reset_n = 1'b0; b_run_en = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0;
    b_in_keep = 5'h1F; b_in_data = '0;
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_pause();
    test_equal_times();
    test_keep_error();
    test_reset_midrun();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_timed_out.md
Name: stream_timed_out

Overview:
- Consumes the 64-bit sample stream produced by the width converter (OUT_BYTES=8). Each sample is {time[31:0], data[31:0]}, LSB side = data.
- Runs a local board-time counter and emits each sample's data word as a one-cycle strobe exactly when the counter equals the sample's time.
- It is the final stage between DMA/width conversion and the experiment output bus. It reports end-of-run and error conditions.

Parameters:
- TIME_BITS, 32, width of sample time field and board_time counter.
- DATA_BITS, 32, width of sample data field and out_data.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- run_en  in  1  1 = board time advances; 0 = pause (counter holds, no output).
- in_data  in  TIME_BITS+DATA_BITS  sample {time,data}.
- in_last  in  1  last sample of run.
- in_keep  in  (TIME_BITS+DATA_BITS)/8  byte enables; must be all 1s.
- in_valid  in  1  AXI-stream valid.
- in_ready  out  1  AXI-stream ready.
- out_data  out  DATA_BITS  data word of last fired sample (holds between strobes).
- out_strobe  out  1  one-cycle pulse with new out_data.
- board_time  out  TIME_BITS  current board time.
- status_run  out  1  state RUN.
- status_end  out  1  state END.
- error_time  out  1  late sample or counter overflow (sticky).
- error_keep  out  1  in_keep not all 1s (sticky).

Behaviour:
- Reset (reset_n=0 at clock edge): all outputs 0, holding register empty, state IDLE. Reset mid-run discards the held sample and the counter immediately.
- Holding register: one sample (hold_time, hold_data, hold_last, hold_valid).
  - in_ready = ~hold_valid | fire, combinational; forced 0 in END and ERROR.
  - Transfer when in_valid & in_ready. Load and fire may occur in the same cycle; the new sample replaces the fired one.
  - Prefetch is allowed in IDLE.
- fire = (state==RUN) & run_en & hold_valid & (hold_time == board_time).
- States:
  - IDLE: board_time=0. run_en=1 -> RUN; board_time stays 0 this cycle.
  - RUN with run_en=1: compare using the current board_time, then board_time <= board_time+1 at the clock edge.
  - RUN with run_en=0: counter holds, fire=0, stays RUN.
  - In RUN, fire with hold_last=1 -> END. Counter stops at fired time+1.
  - In RUN, hold_valid & run_en & hold_time < board_time -> ERROR, error_time=1, no fire.
  - In RUN, run_en=1 & board_time == 2^TIME_BITS-1 -> ERROR, error_time=1; no wrap.
  - Any accepted beat with in_keep != all 1s -> ERROR, error_keep=1. The beat is discarded and never fires. Checked in every state except END/ERROR.
  - END: in_ready=0, status_end=1; held until reset.
  - ERROR: in_ready=0, out_strobe=0, counter frozen; held until reset.
  - If the keep error and the late-time error occur in the same cycle, both flags are set.
- Output timing:
  - On fire in cycle with board_time=t: out_data <= hold_data and out_strobe <= 1 at that edge. Strobe is visible in the cycle where board_time=t+1, width exactly 1 cycle.
  - Consecutive times t, t+1 must produce strobes on consecutive cycles with no gap.
- status_run and status_end are registered state decodes.
- Underflow (RUN, no sample held) is not an error; the counter keeps running. A sample that arrives after its time has passed is late, and the late-time rule applies.
- Equal times in consecutive samples: the second is late -> ERROR.

Test Plan:
- Reset, prefetch {t=0,d=0xA5}, raise run_en -> out_strobe at cycle 1 with out_data=0xA5.
- Samples t=3,4,5 (d=1,2,3) streamed continuously; last flag on t=5 -> strobes at board_time 4,5,6 back-to-back. status_end=1 afterwards, board_time frozen at 6, in_ready=0.
- t=10 held, run_en dropped at board_time 8 for 5 cycles -> no output during pause; strobe at board_time 11 after resume; the 5 paused cycles do not advance the counter.
- Samples t=5 then t=5 -> first fires; second raises error_time the next cycle, state ERROR, in_ready=0, no second strobe.
- Beat with in_keep=0x0F -> error_keep=1, ERROR, no strobe; reset_n=0 one cycle -> all flags 0, board_time=0, IDLE.
- Force board_time near 0xFFFFFFFF (TIME_BITS=8 build: sample t=0xFE, no last) -> strobe at 0xFF; error_time=1 when the counter reaches 0xFF with run_en=1.
